// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix MAC engine: operation modes, FSM
// states, accumulator width derivation and signed saturation.
package matrix_pkg;

  // Working width for saturation. Wide enough for any accumulator this
  // engine can build.
  localparam int SAT_W = 128;

  typedef enum logic [1:0] {
    MODE_MUL      = 2'd0,
    MODE_MUL_BT   = 2'd1,
    MODE_HADAMARD = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Product width plus enough guard bits for MAX_DIM terms, so the sum
  // can never wrap.
  function automatic int acc_width(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

  // Clamp a sign-extended value to the signed range of data_w bits.
  // The result is still SAT_W wide; the caller keeps the low data_w bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int data_w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (data_w - 1)) - one;
    lo  = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One output-row lane: signed multiplier, wide accumulator and a saturated
// view of the running sum with a clamp indication.
module mac_lane
  import matrix_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y,
  output logic                     clamp
);

  localparam int ACC_W = acc_width(DATA_W, MAX_DIM);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [SAT_W-1:0]    acc_ext;
  logic signed [SAT_W-1:0]    sat_full;

  assign prod = a * b;

  // Accumulator: clear wins over accumulate; frozen when the clock enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (enable) begin
      if (clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

  assign acc_ext  = SAT_W'(acc);
  assign sat_full = saturate(acc_ext, DATA_W);
  assign y        = sat_full[DATA_W-1:0];
  assign clamp    = (sat_full != acc_ext);

endmodule

// File: rtl/matrix_mac_engine.sv
// Multi-lane signed matrix engine: C = A*B, A*B^T or A.*B, LANES output rows
// at a time, results streamed out one (row group, column) per write strobe.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; job parameters latched on start
// ST_CHECK | validate dimensions/mode, clear indices and accumulators
// ST_MAC   | one k term per cycle into every active lane
// ST_WRITE | present saturated lane results, advance j / i
// ST_DONE  | final cycle of the job; done/error/sat reported on exit
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int MAX_DIM = 8,
  parameter  int LANES   = 2,
  localparam int DIM_W   = $clog2(MAX_DIM + 1),
  localparam int IDX_W   = $clog2(MAX_DIM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [DIM_W-1:0]                  rows_a,
  input  logic [DIM_W-1:0]                  cols_a,
  input  logic [DIM_W-1:0]                  cols_b,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] a_flat,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] b_flat,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              sat,
  output logic                              c_we,
  output logic [IDX_W-1:0]                  c_row,
  output logic [IDX_W-1:0]                  c_col,
  output logic [LANES-1:0]                  c_lane_valid,
  output logic [LANES*DATA_W-1:0]           c_wdata
);

  state_t           state;
  logic [1:0]       mode_q;
  logic [DIM_W-1:0] n_q, m_q, p_q;
  logic [DIM_W-1:0] i_q, j_q, k_q;
  logic [DIM_W-1:0] k_last;
  logic             job_bad;

  logic signed [DATA_W-1:0] a_mat [MAX_DIM][MAX_DIM];
  logic signed [DATA_W-1:0] b_mat [MAX_DIM][MAX_DIM];

  logic [LANES-1:0]        lane_on;
  logic [LANES-1:0]        lane_clamp;
  logic [LANES*DATA_W-1:0] lane_y;
  logic                    lane_clear;
  logic                    lane_acc;
  logic [IDX_W-1:0]        j_idx, k_idx;

  for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
    for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
      assign a_mat[r][c] = a_flat[(r*MAX_DIM+c)*DATA_W +: DATA_W];
      assign b_mat[r][c] = b_flat[(r*MAX_DIM+c)*DATA_W +: DATA_W];
    end
  end

  assign j_idx = j_q[IDX_W-1:0];
  assign k_idx = k_q[IDX_W-1:0];

  // Hadamard is a single-term "dot product" per element.
  assign k_last = (mode_q == MODE_HADAMARD) ? '0 : m_q - DIM_W'(1);

  assign job_bad = (n_q == '0) || (n_q > DIM_W'(MAX_DIM)) ||
                   (m_q == '0) || (m_q > DIM_W'(MAX_DIM)) ||
                   (p_q == '0) || (p_q > DIM_W'(MAX_DIM)) ||
                   (mode_q == 2'd3) ||
                   ((mode_q == MODE_HADAMARD) && (p_q != m_q));

  assign lane_clear = (state == ST_CHECK) || (state == ST_WRITE);
  assign lane_acc   = (state == ST_MAC);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DIM_W:0]           row;
    logic                     on;
    logic [IDX_W-1:0]         r_idx;
    logic signed [DATA_W-1:0] op_a, op_b;
    logic signed [DATA_W-1:0] y;
    logic                     clamp;

    assign row   = {1'b0, i_q} + (DIM_W+1)'(g);
    assign on    = row < {1'b0, n_q};
    // Rows past N never accumulate; park their index at 0 to stay in range.
    assign r_idx = on ? row[IDX_W-1:0] : '0;

    // Operand selection for this lane's row under the latched mode.
    always_comb begin
      op_a = a_mat[r_idx][k_idx];
      op_b = b_mat[k_idx][j_idx];
      case (mode_q)
        MODE_MUL_BT: begin
          op_b = b_mat[j_idx][k_idx];
        end
        MODE_HADAMARD: begin
          op_a = a_mat[r_idx][j_idx];
          op_b = b_mat[r_idx][j_idx];
        end
        default: ;
      endcase
    end

    mac_lane #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (lane_clear),
      .acc_en (lane_acc && on),
      .a      (op_a),
      .b      (op_b),
      .y      (y),
      .clamp  (clamp)
    );

    assign lane_on[g]                   = on;
    assign lane_clamp[g]                = clamp;
    assign lane_y[g*DATA_W +: DATA_W]   = y;
  end

  // Job sequencing with registered status and write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_q       <= '0;
      n_q          <= '0;
      m_q          <= '0;
      p_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      sat          <= 1'b0;
      c_we         <= 1'b0;
      c_row        <= '0;
      c_col        <= '0;
      c_lane_valid <= '0;
      c_wdata      <= '0;
    end else if (enable) begin
      done         <= 1'b0;
      c_we         <= 1'b0;
      c_row        <= '0;
      c_col        <= '0;
      c_lane_valid <= '0;
      c_wdata      <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            n_q    <= rows_a;
            m_q    <= cols_a;
            p_q    <= cols_b;
            sat    <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (job_bad) begin
            error <= 1'b1;
            state <= ST_DONE;
          end else begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k_q == k_last) begin
            state <= ST_WRITE;
          end else begin
            k_q <= k_q + DIM_W'(1);
          end
        end
        ST_WRITE: begin
          c_we         <= 1'b1;
          c_row        <= i_q[IDX_W-1:0];
          c_col        <= j_idx;
          c_lane_valid <= lane_on;
          c_wdata      <= lane_y;
          if (|(lane_clamp & lane_on)) sat <= 1'b1;
          k_q <= '0;
          if (({1'b0, j_q} + (DIM_W+1)'(1)) < {1'b0, p_q}) begin
            j_q   <= j_q + DIM_W'(1);
            state <= ST_MAC;
          end else if (({1'b0, i_q} + (DIM_W+1)'(LANES)) < {1'b0, n_q}) begin
            i_q   <= i_q + DIM_W'(LANES);
            j_q   <= '0;
            state <= ST_MAC;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: a table of hand-computed jobs run
// back to back, then sequences for stalls, restarts, reset and a full 8x8 job.
module tb_matrix_mac_engine;

  localparam int NOSTALL = 100000;
  localparam int NOSTART = -1;
  localparam int NV      = 13;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          start;
  logic [1:0]    mode;
  logic [3:0]    rows_a, cols_a, cols_b;
  logic [2047:0] a_flat, b_flat;
  logic          busy, done, error, sat, c_we;
  logic [2:0]    c_row, c_col;
  logic [1:0]    c_lane_valid;
  logic [63:0]   c_wdata;

  matrix_mac_engine dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .mode         (mode),
    .rows_a       (rows_a),
    .cols_a       (cols_a),
    .cols_b       (cols_b),
    .a_flat       (a_flat),
    .b_flat       (b_flat),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .sat          (sat),
    .c_we         (c_we),
    .c_row        (c_row),
    .c_col        (c_col),
    .c_lane_valid (c_lane_valid),
    .c_wdata      (c_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [1:0]    mode;
    int            n, m, p;
    logic [2047:0] a, b;
    int            cyc;
    int            nw;
    logic          err;
    logic          sat;
    logic [71:0]   w0, w1;
  } vec_t;

  vec_t        tv [NV];
  logic [71:0] wr_q [$];
  int          got_cyc;
  logic        got_err, got_sat;
  int          passed = 0;
  int          total  = 0;

  function automatic logic [2047:0] put(input logic [2047:0] f, input int r, input int c, input int v);
    logic [2047:0] t;
    t = f;
    t[(r*8+c)*32 +: 32] = 32'(v);
    return t;
  endfunction

  function automatic logic [2047:0] m2(input int e00, input int e01, input int e10, input int e11);
    logic [2047:0] f;
    f = '0;
    f = put(f, 0, 0, e00);
    f = put(f, 0, 1, e01);
    f = put(f, 1, 0, e10);
    f = put(f, 1, 1, e11);
    return f;
  endfunction

  function automatic logic [71:0] wr(input int row, input int col, input logic [1:0] v,
                                     input int d1, input int d0);
    return {3'(row), 3'(col), v, 32'(d1), 32'(d0)};
  endfunction

  function automatic vec_t mkv(input string name, input logic [1:0] md, input int n, input int m,
                               input int p, input logic [2047:0] a, input logic [2047:0] b,
                               input int cyc, input int nw, input logic err, input logic st,
                               input logic [71:0] w0, input logic [71:0] w1);
    vec_t v;
    v.name = name; v.mode = md; v.n = n; v.m = m; v.p = p; v.a = a; v.b = b;
    v.cyc = cyc; v.nw = nw; v.err = err; v.sat = st; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  function automatic logic [71:0] wq(input int idx);
    if (idx < wr_q.size()) return wr_q[idx];
    return '1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Start a job, count cycles from the start-sampling edge to done, log writes.
  task automatic run_job(input vec_t v, input int stall_at, input int stall_len, input int restart_at);
    int   cnt;
    logic en_edge;
    wr_q.delete();
    got_cyc = -1;
    got_err = 1'b0;
    got_sat = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    mode   = v.mode;
    rows_a = 4'(v.n);
    cols_a = 4'(v.m);
    cols_b = 4'(v.p);
    a_flat = v.a;
    b_flat = v.b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt   = 0;
    while (cnt < 1000) begin
      @(negedge clk);
      enable  = !((cnt >= stall_at) && (cnt < stall_at + stall_len));
      start   = (cnt == restart_at);
      en_edge = enable;
      @(posedge clk); #1;
      cnt++;
      if (en_edge && c_we) wr_q.push_back({c_row, c_col, c_lane_valid, c_wdata});
      if (done) begin
        got_cyc = cnt;
        got_err = error;
        got_sat = sat;
        break;
      end
    end
    start  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic check_job(input vec_t v);
    chk($sformatf("%s.cyc", v.name), 128'(got_cyc), 128'(v.cyc));
    chk($sformatf("%s.nwrites", v.name), 128'(wr_q.size()), 128'(v.nw));
    chk($sformatf("%s.error", v.name), 128'(got_err), 128'(v.err));
    chk($sformatf("%s.sat", v.name), 128'(got_sat), 128'(v.sat));
    if (v.nw >= 1) chk($sformatf("%s.write0", v.name), 128'(wq(0)), 128'(v.w0));
    if (v.nw >= 2) chk($sformatf("%s.write1", v.name), 128'(wq(1)), 128'(v.w1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t          s;
    logic [2047:0] a, b, ia, ib;
    int            bad;

    a  = m2(1, 2, 3, 4);
    b  = m2(5, 6, 7, 8);
    tv[0]  = mkv("mul",      2'd0, 2, 2, 2, a, b, 8, 2, 0, 0, wr(0,0,2'b11,43,19), wr(0,1,2'b11,50,22));
    tv[1]  = mkv("mul_bt",   2'd1, 2, 2, 2, a, b, 8, 2, 0, 0, wr(0,0,2'b11,39,17), wr(0,1,2'b11,53,23));
    ia = put(put(put('0, 0, 0, 2), 1, 0, 3), 2, 0, 4);
    ib = put('0, 0, 0, 5);
    tv[2]  = mkv("odd_n",    2'd0, 3, 1, 1, ia, ib, 6, 2, 0, 0, wr(0,0,2'b11,15,10), wr(2,0,2'b01,0,20));
    ia = put('0, 0, 0, 32'h7FFF_FFFF);
    tv[3]  = mkv("sat_pos",  2'd0, 1, 1, 1, ia, ia, 4, 1, 0, 1, wr(0,0,2'b01,0,32'h7FFF_FFFF), '0);
    ia = put('0, 0, 0, 1);
    tv[4]  = mkv("sat_clr",  2'd0, 1, 1, 1, ia, ia, 4, 1, 0, 0, wr(0,0,2'b01,0,1), '0);
    tv[5]  = mkv("hadamard", 2'd2, 2, 2, 2, a, b, 6, 2, 0, 0, wr(0,0,2'b11,21,5), wr(0,1,2'b11,32,12));
    ia = put(put('0, 0, 0, -3), 0, 1, 2);
    ib = put(put('0, 0, 0, 4), 1, 0, 5);
    tv[6]  = mkv("signed",   2'd0, 1, 2, 1, ia, ib, 5, 1, 0, 0, wr(0,0,2'b01,0,32'hFFFF_FFFE), '0);
    ia = put('0, 0, 0, 32'h8000_0000);
    ib = put('0, 0, 0, 32'h7FFF_FFFF);
    tv[7]  = mkv("sat_neg",  2'd0, 1, 1, 1, ia, ib, 4, 1, 0, 1, wr(0,0,2'b01,0,32'h8000_0000), '0);
    tv[8]  = mkv("rej_m0",   2'd0, 2, 0, 2, a, b, 2, 0, 1, 0, '0, '0);
    tv[9]  = mkv("rej_mode3",2'd3, 2, 2, 2, a, b, 2, 0, 1, 0, '0, '0);
    tv[10] = mkv("rej_m9",   2'd0, 2, 9, 2, a, b, 2, 0, 1, 0, '0, '0);
    tv[11] = mkv("rej_had_p",2'd2, 2, 2, 1, a, b, 2, 0, 1, 0, '0, '0);
    ia = put(put(put('0, 0, 0, 1), 0, 1, 2), 0, 2, 3);
    ib = put(put(put(put(put(put('0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4), 2, 0, 5), 2, 1, 6);
    tv[12] = mkv("rect",     2'd0, 1, 3, 2, ia, ib, 10, 2, 0, 0, wr(0,0,2'b01,0,22), wr(0,1,2'b01,0,28));

    reset = 1'b1; enable = 1'b1; start = 1'b0; mode = '0;
    rows_a = '0; cols_a = '0; cols_b = '0; a_flat = '0; b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", 128'({busy, done, error, sat, c_we, c_lane_valid, c_row, c_col}), '0);
    chk("reset_wdata", 128'(c_wdata), '0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < NV; t++) begin
      run_job(tv[t], NOSTALL, 0, NOSTART);
      check_job(tv[t]);
    end

    // Five stalled cycles just after the first write push done out by five.
    run_job(tv[0], 4, 5, NOSTART);
    s = tv[0]; s.name = "stall"; s.cyc = 13;
    check_job(s);

    // A start pulse mid-job must not disturb it.
    run_job(tv[0], NOSTALL, 0, 3);
    s = tv[0]; s.name = "start_busy";
    check_job(s);

    // A start pulse in the DONE cycle is dropped.
    run_job(tv[1], NOSTALL, 0, 7);
    s = tv[1]; s.name = "start_done";
    check_job(s);
    @(posedge clk); #1;
    chk("start_done_idle", 128'({busy, done}), '0);

    // Reset during the third MAC cycle of an M=4 job aborts it.
    @(negedge clk);
    mode = 2'd0; rows_a = 4'd2; cols_a = 4'd4; cols_b = 4'd1;
    a_flat = a; b_flat = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_busy", 128'(busy), '0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c_we || done || busy || (c_wdata != '0)) bad++;
    end
    chk("reset_mid_quiet", 128'(bad), '0);

    run_job(tv[0], NOSTALL, 0, NOSTART);
    s = tv[0]; s.name = "after_reset";
    check_job(s);

    // Full-size job: identity times B reproduces B, two rows per write.
    ia = '0;
    ib = '0;
    for (int r = 0; r < 8; r++) begin
      ia = put(ia, r, r, 1);
      for (int c = 0; c < 8; c++) ib = put(ib, r, c, r*8 + c + 1);
    end
    s = mkv("full8", 2'd0, 8, 8, 8, ia, ib, 290, 32, 0, 0, wr(0,0,2'b11,9,1), wr(0,1,2'b11,10,2));
    run_job(s, NOSTALL, 0, NOSTART);
    check_job(s);
    for (int w = 0; w < 32; w++) begin
      int row, col;
      row = (w / 8) * 2;
      col = w % 8;
      chk($sformatf("full8.w%0d", w), 128'(wq(w)),
          128'(wr(row, col, 2'b11, (row+1)*8 + col + 1, row*8 + col + 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/matrix_mac_engine.md
# matrix_mac_engine

Parametrised, multi-lane successor to the fixed 32-bit matrix multiplier in the accelerator datapath. It computes C = A·B, C = A·Bᵀ or the element-wise product A∘B on signed integer matrices of run-time size up to MAX_DIM×MAX_DIM. It processes LANES output rows in parallel and streams results out through a write port instead of holding a full output array. It sits behind the operation-register decoder, which supplies the dimensions, the mode and a start pulse.

## Interface
- DATA_W, 32, signed element width of A, B and C.
- MAX_DIM, 8, maximum rows or columns of any operand.
- LANES, 2, output rows computed in parallel (1..MAX_DIM).
- ACC_W, 2*DATA_W+$clog2(MAX_DIM), accumulator width (derived, not overridable).
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  clock enable; when low, all state holds and no write is issued.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  2  0 = MUL, 1 = MUL_BT (A·Bᵀ), 2 = HADAMARD, 3 = reserved (rejected).
- rows_a  in  $clog2(MAX_DIM+1)  N.
- cols_a  in  $clog2(MAX_DIM+1)  M.
- cols_b  in  $clog2(MAX_DIM+1)  P. In MUL_BT this is the number of rows of B.
- a_flat, b_flat  in  MAX_DIM*MAX_DIM*DATA_W  row-major; element (r,c) is at bit offset (r*MAX_DIM+c)*DATA_W. The inputs must be held stable while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at job end.
- error  out  1  valid with done; high if the job was rejected.
- sat  out  1  valid with done; high if any output saturated.
- c_we  out  1  write strobe.
- c_row  out  $clog2(MAX_DIM)  row of lane 0; lane g writes row c_row+g.
- c_col  out  $clog2(MAX_DIM)  column.
- c_lane_valid  out  LANES  per-lane write mask.
- c_wdata  out  LANES*DATA_W  lane g is at bits [g*DATA_W +: DATA_W].

## Operation
- States: IDLE → CHECK → MAC → WRITE → (MAC | DONE) → IDLE.
- IDLE: on start, latch mode, N, M and P, clear the sat flag, and go to CHECK. While not in IDLE, start is ignored.
- CHECK: the job is rejected if N, M or P is 0 or greater than MAX_DIM, or if mode is 3. A rejected job goes to DONE with error=1 and issues no writes. Otherwise clear i, j, k and the accumulators, and go to MAC.
- MAC: each lane g with i+g<N adds a product to its accumulator:
  - MUL: A[i+g][k]·B[k][j].
  - MUL_BT: A[i+g][k]·B[j][k].
  - HADAMARD: A[i+g][j]·B[i+g][j]. M is treated as 1, and P must equal M (cols_a); otherwise the job is rejected in CHECK.
  - k runs 0..M-1, one value per cycle. After the last k, go to WRITE.
- Arithmetic: operands are signed DATA_W and the product is signed 2·DATA_W. Accumulation is in signed ACC_W, which cannot overflow. At WRITE the result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clamp sets sat, which stays set until the next start.
- WRITE: c_we=1 with c_row=i, c_col=j, c_lane_valid[g]=(i+g<N), and the saturated values. Then clear the accumulators and k.
  - If j<P-1: j++, go to MAC.
  - Else if i+LANES<N: i+=LANES, j=0, go to MAC.
  - Else go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.

## Timing
- Reset: state=IDLE; busy, done, error, sat and c_we are 0; c_row, c_col, c_lane_valid and c_wdata are 0; i, j, k and the accumulators are 0.
- Reset mid-job aborts immediately. No further writes occur and no done pulse is generated.
- Let G = ceil(N/LANES). For a valid job, done rises exactly 2 + G·P·(M+1) enabled cycles after the edge that samples start. For HADAMARD, M=1 in this formula.
- A rejected job: done and error rise 2 enabled cycles after start.
- c_we is a single-cycle pulse per (row group, column), for exactly G·P pulses. Outputs are registered. c_wdata is valid only while c_we=1 and is otherwise 0.
- When enable is low, the cycle is not counted. A c_we pulse or a done pulse that is high stays high until the next enabled cycle.
- Start in the DONE cycle is ignored. Start in the cycle after DONE (IDLE) is accepted.

## Structure
- matrix_pkg holds:
  - the mode enum (MODE_MUL, MODE_MUL_BT, MODE_HADAMARD);
  - the state enum;
  - the ACC_W derivation function;
  - the saturate-to-DATA_W function.
- Sub-module mac_lane holds one signed multiplier, the ACC_W accumulator, clear/accumulate controls and a saturating output with a clamp flag. It is instantiated LANES times by a generate loop. The controlling FSM and the operand selection stay in matrix_mac_engine.

## Test plan
- MUL with defaults: A=[[1,2],[3,4]], B=[[5,6],[7,8]] (N=M=P=2) → writes (row 0, col 0) [19,43] and (row 0, col 1) [22,50]; exactly 2 c_we pulses; done at cycle 2+1·2·3=8; error=0, sat=0.
- MUL_BT, same A, B → row-0 writes [17,39] then [23,53].
- Odd N=3, LANES=2, M=P=1, A=[2,3,4]ᵀ, B=[[5]] → second write has c_lane_valid=01, data lane 0 = 20; done at cycle 2+2·1·2=6.
- Saturation: N=M=P=1, A=B=0x7FFFFFFF → c_wdata=0x7FFFFFFF, sat=1; next job with A=B=1 gives sat=0.
- Rejection: cols_a=0, or mode=3, or cols_a=9 → done and error at cycle 2, no c_we.
- Robustness:
  - reset asserted during the 3rd MAC cycle → no writes afterwards, busy=0 next cycle;
  - enable low for 5 cycles mid-job → done is delayed by exactly 5;
  - start while busy has no effect.
